int_ctrl: RTL and testbench

Interrupt controller sitting directly upstream of the CPU interrupt input int_e[7:0].
- Captures rising edges on 8 peripheral request lines and holds them as pending.
- Applies a software mask and priority-encodes the unmasked pending lines.
- Presents one one-hot request to the CPU and tracks it through an acknowledge/return handshake.
- Mask and pending registers are memory-mapped on a small 8-bit register port.

---
 rtl/int_ctrl_pkg.sv | 18 +
 rtl/irq_edge_sync.sv | 48 ++++
 rtl/int_ctrl.sv | 122 ++++++++++++
 tb/tb_int_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared FSM state encoding and register addresses for int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_SERVICE = 2'd2;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_ACT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/irq_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_edge_sync
// Description : One request line: optional 2-flop synchronizer (INT_SYNC_EN)
//               followed by a rising-edge detector producing a 1-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic rise
);

    logic w_seen;
    logic r_prev;

`ifdef INT_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_seen = r_sync2;
`else
    assign w_seen = irq;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_seen;
        end
    end

    assign rise = w_seen & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Edge-capturing, maskable, fixed-priority interrupt controller
//               with ack/return handshake. Optional input sync: INT_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int               N_IRQ    = 8,
    parameter logic [N_IRQ-1:0] RST_MASK = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    output logic [N_IRQ-1:0] int_e,
    input  logic             int_ack,
    input  logic             int_done,
    input  logic             reg_we,
    input  logic [1:0]       reg_addr,
    input  logic [7:0]       reg_wdata,
    output logic [7:0]       reg_rdata
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_act;
    logic [N_IRQ-1:0] r_int_e;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_elig;
    logic [N_IRQ-1:0] w_pick;
    logic [N_IRQ-1:0] w_pend_clr;
    logic [N_IRQ-1:0] w_ack_clr;
    logic             w_take_req;
    logic             w_take_ack;
    logic             w_drop;
    logic             w_take_done;

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_edge
            irq_edge_sync u_edge (
                .clk   (clk),
                .reset (reset),
                .irq   (irq[gi]),
                .rise  (w_rise[gi])
            );
        end
    endgenerate

    // Bit 0 is highest priority: isolate the lowest set eligible bit.
    assign w_elig     = r_pend & r_mask;
    assign w_pick     = w_elig & (~w_elig + 1'b1);
    assign w_pend_clr = (reg_we && reg_addr == ADDR_PEND) ? reg_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (|w_elig) w_state_nxt = c_ST_REQ;
            end
            c_ST_REQ: begin
                if (int_ack)                         w_state_nxt = c_ST_SERVICE;
                else if ((r_int_e & w_elig) == '0)   w_state_nxt = c_ST_IDLE;
            end
            c_ST_SERVICE: begin
                if (int_done) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // A presented line that lost its mask or pending bit is withdrawn.
    always_comb begin
        w_take_req  = (r_state == c_ST_IDLE) && (|w_elig);
        w_take_ack  = (r_state == c_ST_REQ) && int_ack;
        w_drop      = (r_state == c_ST_REQ) && !int_ack && ((r_int_e & w_elig) == '0);
        w_take_done = (r_state == c_ST_SERVICE) && int_done;
        w_ack_clr   = w_take_ack ? r_int_e : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask  <= RST_MASK;
            r_pend  <= '0;
            r_act   <= '0;
            r_int_e <= '0;
        end else begin
            if (reg_we && reg_addr == ADDR_MASK) r_mask <= reg_wdata;
            // A new edge outranks any clear of the same bit.
            r_pend <= (r_pend & ~(w_pend_clr | w_ack_clr)) | w_rise;
            if (w_take_req)               r_int_e <= w_pick;
            else if (w_take_ack || w_drop) r_int_e <= '0;
            if (w_take_ack)       r_act <= r_int_e;
            else if (w_take_done) r_act <= '0;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            ADDR_MASK: reg_rdata = r_mask;
            ADDR_PEND: reg_rdata = r_pend;
            ADDR_ACT:  reg_rdata = r_act;
            default:   reg_rdata = 8'h00;
        endcase
    end

    assign int_e = r_int_e;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Scoreboard bench for int_ctrl: directed scenarios plus random
//               traffic against a behavioural model. Honours INT_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    localparam logic [7:0] c_RST_MASK = 8'h24;
`ifdef INT_SYNC_EN
    localparam int c_SYNC = 2;
`else
    localparam int c_SYNC = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq = 8'h00;
    logic [7:0] int_e;
    logic       int_ack = 1'b0;
    logic       int_done = 1'b0;
    logic       reg_we = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] reg_rdata;

    always #5 clk = ~clk;

    int_ctrl #(.N_IRQ(8), .RST_MASK(c_RST_MASK)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .int_e     (int_e),
        .int_ack   (int_ack),
        .int_done  (int_done),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] int_e;
        logic [7:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    // Model: presented line index and in-service line index (-1 = none).
    logic [7:0] m_mask, m_pend, m_prev, m_s1, m_s2;
    int         m_pres, m_act;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] onehot(input int idx);
        logic [7:0] one;
        one = 8'h01;
        return (idx < 0) ? 8'h00 : (one << idx);
    endfunction

    function automatic logic [7:0] exp_rdata(input logic [1:0] ad);
        case (ad)
            2'd0:    return m_mask;
            2'd1:    return m_pend;
            2'd2:    return onehot(m_act);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_mask = c_RST_MASK;
        m_pend = 8'h00;
        m_prev = 8'h00;
        m_s1   = 8'h00;
        m_s2   = 8'h00;
        m_pres = -1;
        m_act  = -1;
    endtask

    task automatic model_step(input logic [7:0] i, input logic a, input logic d,
                              input logic we, input logic [1:0] ad, input logic [7:0] wd);
        logic [7:0] seen, npend;
        int np, na;
`ifdef INT_SYNC_EN
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = i;
`else
        seen = i;
`endif
        np = m_pres;
        na = m_act;
        if (m_pres >= 0) begin
            if (a) begin
                na = m_pres;
                np = -1;
            end else if (!(m_pend[m_pres] && m_mask[m_pres])) begin
                np = -1;
            end
        end else if (m_act >= 0) begin
            if (d) na = -1;
        end else begin
            for (int k = 7; k >= 0; k--)
                if (m_pend[k] && m_mask[k]) np = k;
        end
        npend = m_pend;
        for (int k = 0; k < 8; k++) begin
            if (seen[k] && !m_prev[k])
                npend[k] = 1'b1;
            else if ((we && ad == 2'd1 && wd[k]) || (m_pres == k && a))
                npend[k] = 1'b0;
        end
        if (we && ad == 2'd0) m_mask = wd;
        m_pend = npend;
        m_prev = seen;
        m_pres = np;
        m_act  = na;
    endtask

    task automatic apply(input logic [7:0] i, input logic a, input logic d,
                         input logic we, input logic [1:0] ad, input logic [7:0] wd);
        exp_t e;
        irq = i; int_ack = a; int_done = d;
        reg_we = we; reg_addr = ad; reg_wdata = wd;
        model_step(i, a, d, we, ad, wd);
        e.int_e = onehot(m_pres);
        e.rdata = exp_rdata(ad);
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic [7:0] i, input logic a, input logic d,
                       input logic we, input logic [1:0] ad, input logic [7:0] wd);
        @(negedge clk);
        apply(i, a, d, we, ad, wd);
    endtask

    task automatic idle(input int n, input logic [1:0] ad);
        for (int k = 0; k < n; k++) cyc(8'h00, 1'b0, 1'b0, 1'b0, ad, 8'h00);
    endtask

    // Bounded wait (model-driven) for a presented request, then acknowledge it.
    task automatic ack_when_req();
        for (int k = 0; k < 12 && m_pres < 0; k++) idle(1, 2'd0);
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
    endtask

    task automatic reset_checks();
        #1 check("reset_int_e", int_e, 8'h00);
        for (int ad = 0; ad < 3; ad++) begin
            reg_addr = 2'(ad);
            #1 check("reset_rdata", reg_rdata, (ad == 0) ? c_RST_MASK : 8'h00);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("int_e", int_e, e.int_e);
                check("reg_rdata", reg_rdata, e.rdata);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] rirq;
        repeat (3) @(negedge clk);
        reset_checks();
        release_reset();

        // Single request, full handshake.
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFF);
        cyc(8'h08, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
        idle(1 + c_SYNC, 2'd1);
        ack_when_req();
        idle(2, 2'd1);
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
        idle(2, 2'd2);

        // Simultaneous requests: priority order.
        cyc(8'h22, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
        ack_when_req();
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
        ack_when_req();
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
        idle(2, 2'd1);

        // Masked request becomes eligible when unmasked.
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
        cyc(8'h04, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
        idle(3 + c_SYNC, 2'd1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h04);
        idle(3, 2'd1);
        ack_when_req();
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00);

        // Mask drop while presenting: withdraw, keep pending.
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFF);
        cyc(8'h10, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
        for (int k = 0; k < 12 && m_pres < 0; k++) idle(1, 2'd1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
        idle(3, 2'd1);

        // Pending clear while presenting withdraws the request.
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFF);
        for (int k = 0; k < 12 && m_pres < 0; k++) idle(1, 2'd1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 8'hFF);
        idle(3, 2'd1);

        // Edge capture beats same-cycle write-1-to-clear.
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
        for (int k = 0; k <= c_SYNC; k++)
            cyc(8'h01, 1'b0, 1'b0, (k == c_SYNC), 2'd1, 8'h01);
        idle(1, 2'd1);
        cyc(8'h01, 1'b0, 1'b0, 1'b1, 2'd1, 8'h01);
        idle(3, 2'd1);

        // Reset in the middle of service.
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFF);
        cyc(8'h40, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
        ack_when_req();
        idle(1, 2'd2);
        @(posedge clk);
        #3 reset = 1'b1;
        irq = 8'h00; int_ack = 1'b0; int_done = 1'b0; reg_we = 1'b0;
        reset_checks();
        release_reset();

        // Random traffic.
        rirq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            rirq ^= 8'($urandom & $urandom & $urandom);
            cyc(rirq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), 8'($urandom));
        end
        idle(2, 2'd0);

        repeat (3) @(posedge clk);
        #2 check("queue_drained", 8'(sb_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
